noc_data_enc_mc: RTL

NOC_DATA_ENC_MC -- requirements
Module: noc_data_enc_mc

---
 rtl/noc_data_enc_mc.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/noc_data_enc_mc.sv
// Packs FIFO words into NoC packets tagged with PE row/column. Unicast mode
// targets each PE; multicast mode targets a whole row.
module noc_data_enc_mc #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_ROW    = 4,
  parameter int NUM_COL    = 4,
  localparam int RW = (NUM_ROW > 1) ? $clog2(NUM_ROW) : 1,
  localparam int CW = (NUM_COL > 1) ? $clog2(NUM_COL) : 1,
  localparam int PW = 1 + RW + CW + DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic                  mode,
  input  logic [7:0]            kernel_size,
  input  logic [7:0]            num_channel,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  pkt_valid,
  input  logic                  pkt_ready,
  output logic [PW-1:0]         pkt_data,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SEND  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam int         MIN_RC_I = (NUM_ROW < NUM_COL) ? NUM_ROW : NUM_COL;
  localparam logic [7:0] MIN_RC   = MIN_RC_I[7:0];

  logic [1:0]      r_state;
  logic            r_mode;
  logic [7:0]      r_k;
  logic [7:0]      r_c;
  logic [7:0]      r_q;
  logic [7:0]      r_r;
  logic [7:0]      r_ch;
  logic            r_inflight;
  logic [RW-1:0]   r_tag_row;
  logic [CW-1:0]   r_tag_col;
  logic [PW-1:0]   r_q0;
  logic [PW-1:0]   r_q1;
  logic [1:0]      r_cnt;
  logic            r_done;
  logic            r_cfg_err;

  logic            w_pop;
  logic [2:0]      w_occ_next;
  logic            w_rd_en;
  logic            w_last;
  logic            w_cfg_ok;
  logic [PW-1:0]   w_new_pkt;

  assign w_pop      = (r_cnt != 2'd0) && pkt_ready;
  // Room check counts the word already in flight so the queue can never overflow.
  assign w_occ_next = {1'b0, r_cnt} + {2'b0, r_inflight} - {2'b0, w_pop};
  assign w_rd_en    = (r_state == S_SEND) && !fifo_empty && (w_occ_next < 3'd2);
  assign w_last     = (r_q == r_k - 8'd1) && (r_r == r_k - 8'd1) && (r_ch == r_c - 8'd1);
  assign w_cfg_ok   = (kernel_size != 8'd0) && (kernel_size <= MIN_RC) && (num_channel != 8'd0);
  assign w_new_pkt  = {r_mode, r_tag_row, r_tag_col, fifo_rd_data};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= S_IDLE;
      r_mode    <= 1'b0;
      r_k       <= 8'd0;
      r_c       <= 8'd0;
      r_q       <= 8'd0;
      r_r       <= 8'd0;
      r_ch      <= 8'd0;
      r_done    <= 1'b0;
      r_cfg_err <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_cfg_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (w_cfg_ok) begin
              r_mode  <= mode;
              r_k     <= kernel_size;
              r_c     <= num_channel;
              r_q     <= 8'd0;
              r_r     <= 8'd0;
              r_ch    <= 8'd0;
              r_state <= S_SEND;
            end else begin
              r_cfg_err <= 1'b1;
            end
          end
        end
        S_SEND: begin
          if (w_rd_en) begin
            if (r_q == r_k - 8'd1) begin
              r_q <= 8'd0;
              if (r_r == r_k - 8'd1) begin
                r_r  <= 8'd0;
                r_ch <= r_ch + 8'd1;
              end else begin
                r_r <= r_r + 8'd1;
              end
            end else begin
              r_q <= r_q + 8'd1;
            end
            if (w_last) r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if ((r_cnt == 2'd0) && !r_inflight) begin
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // The (row, col) tag is captured with the request and travels with the read.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_inflight <= 1'b0;
      r_tag_row  <= '0;
      r_tag_col  <= '0;
    end else begin
      r_inflight <= w_rd_en;
      if (w_rd_en) begin
        r_tag_row <= r_r[RW-1:0];
        r_tag_col <= r_mode ? '0 : r_q[CW-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_q0  <= '0;
      r_q1  <= '0;
      r_cnt <= 2'd0;
    end else begin
      if (r_inflight && w_pop) begin
        if (r_cnt == 2'd1) begin
          r_q0 <= w_new_pkt;
        end else begin
          r_q0 <= r_q1;
          r_q1 <= w_new_pkt;
        end
      end else if (r_inflight) begin
        if (r_cnt == 2'd0) r_q0 <= w_new_pkt;
        else               r_q1 <= w_new_pkt;
        r_cnt <= r_cnt + 2'd1;
      end else if (w_pop) begin
        r_q0  <= r_q1;
        r_cnt <= r_cnt - 2'd1;
      end
    end
  end

  assign fifo_rd_en = w_rd_en;
  assign pkt_valid  = (r_cnt != 2'd0);
  assign pkt_data   = r_q0;
  assign busy       = (r_state != S_IDLE);
  assign done       = r_done;
  assign cfg_err    = r_cfg_err;

endmodule
